kmap4_sweep_ctrl: RTL and testbench
===================================

Name: kmap4_sweep_ctrl

Overview:
- Sequencer that exhaustively drives a 4-input combinational function block (inputs D,C,B,A; output F), e.g. k_map_4.
- For each of the 16 minterms it applies the vector, waits a settle time, then samples F into a 16-bit truth table.
- Compares the sampled table against an expected minterm mask and reports pass/fail.
- Sits between the lab's K-map datapath and a board-level start button / LED display; replaces hand-written stimulus sequences.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate the sweep in progress.
- expected  input  16  expected F per minterm; bit i corresponds to {D,C,B,A}==i.
- f_in  input  1  F output of the function block.
- d_out  output  1  drive to the function block's D input (MSB).
- c_out  output  1  drive to the function block's C input.
- b_out  output  1  drive to the function block's B input.
- a_out  output  1  drive to the function block's A input (LSB).
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse when a sweep completes; not raised on abort.
- truth_table  output  16  sampled F; bit i = F at minterm i.
- mismatch_cnt  output  5  number of minterms where f_in != expected (0..16).
- pass  output  1  high when mismatch_cnt==0 after a completed sweep.

Behaviour:
- Reset (async, rst_n low), all outputs 0:
  - state=IDLE; d/c/b/a_out=0; busy=0; done=0; truth_table=0; mismatch_cnt=0; pass=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → clear truth_table, mismatch_cnt and pass; step index=0; drive vector 0; load settle counter; go to SETTLE.
  - Outputs driven in the first SETTLE cycle.
- SETTLE:
  - Counter decrements each cycle.
  - Spends exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle):
  - Write truth_table[m] = f_in, where m is the current minterm.
  - If f_in != expected[m], increment mismatch_cnt.
  - If step index == 15, go to DONE.
  - Otherwise, step index+1; drive next vector on the same edge; reload counter; go to SETTLE.
- DONE (1 cycle):
  - done=1; pass = (mismatch_cnt==0), including the final SAMPLE's contribution.
  - Go to IDLE. busy is low in DONE.
- Vector outputs hold their last value (minterm 15 in binary order) after DONE until the next start.
- Latency: start accepted at edge 0 → done high for the cycle after edge 16*(SETTLE_CYCLES+1)+1. With default SETTLE_CYCLES=2, that is 49 cycles after start.
- start while busy: ignored. start asserted in the DONE cycle: ignored; must be re-asserted in IDLE.
- abort (any non-IDLE state): next edge → IDLE, busy=0, done stays 0, pass=0. truth_table and mismatch_cnt keep their partial values. abort has priority over SAMPLE-stage updates in the same cycle.
- abort in IDLE: no effect.
- start and abort together in IDLE: start wins.
- mismatch_cnt is 5 bits, so 16 mismatches = 5'd16 with no wrap.
- expected is sampled live at each SAMPLE; it must be held stable during a sweep. Changing it mid-sweep is legal but only affects later minterms.
- rst_n asserted mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: KMAP4_GRAY_ORDER_EN.
- Defined: step index s drives minterm m = s ^ (s>>1), i.e. Gray/K-map adjacency order 0,1,3,2,6,7,5,4,12,...,8. Only one input toggles per step. truth_table and expected are still indexed by binary minterm m.
- Undefined: m = s (binary order 0..15).
- Both builds produce identical final truth_table, mismatch_cnt, pass and latency.

Decomposition:
- Package kmap4_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - NUM_VECTORS=16; IDX_W=4; MISMATCH_W=5;
  - function step_to_minterm(step), which contains the macro-selected mapping.
- Sub-module kmap4_vec_gen: step index in → minterm and d/c/b/a_out registered out, with load/advance controls. Isolates the Gray/binary ordering from the FSM.

Test Plan:
- F = D&C | ~B&A model (table 16'hF222), expected=16'hF222, start → done at cycle 49; truth_table=16'hF222, mismatch_cnt=0, pass=1.
- Same model, expected=16'hF223 → mismatch_cnt=1, pass=0, truth_table=16'hF222.
- f_in tied 1, expected=16'h0000 → mismatch_cnt=16, pass=0, truth_table=16'hFFFF.
- Pulse abort at cycle 20 → busy low at the next edge, done never pulses, pass=0. Follow with a new start → a full clean sweep passes.
- rst_n low at cycle 30 → all outputs 0 immediately; start held during busy → no restart and no extra done.
- With KMAP4_GRAY_ORDER_EN: log vectors → sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, exactly one input bit changing per step; final results identical to the first scenario.

Source files
------------

// File: rtl/kmap4_pkg.sv
// ----------------------------------------------------------------------------
// kmap4_pkg
// Shared types and constants for the 4-input K-map sweep controller.
//
// Contents:
//   state_e          sweep FSM state encoding
//   NUM_VECTORS      number of minterms swept (16)
//   IDX_W            width of a step index / minterm number
//   MISMATCH_W       width of the mismatch counter (holds 0..16 without wrap)
//   step_to_minterm  maps a sweep step to the minterm driven at that step
//
// Build option:
//   KMAP4_GRAY_ORDER_EN  when defined, steps walk the minterms in Gray
//                        (K-map adjacency) order. When undefined, they walk
//                        them in binary order.
// ----------------------------------------------------------------------------
package kmap4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int MISMATCH_W  = 5;

  // Gray order toggles exactly one function input per step, so glitches seen
  // on F can be attributed to a single input transition.
  function automatic logic [IDX_W-1:0] step_to_minterm(input logic [IDX_W-1:0] step);
`ifdef KMAP4_GRAY_ORDER_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage : kmap4_pkg

// File: rtl/kmap4_vec_gen.sv
// ----------------------------------------------------------------------------
// kmap4_vec_gen
// Holds the sweep step index and the registered minterm vector driven onto
// the function block's D/C/B/A inputs. The step-to-minterm ordering lives
// here so the FSM only deals with "load" and "advance".
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_i      in   restart at step 0 (takes priority over advance_i)
//   advance_i   in   move to the next step
//   minterm_o   out  minterm currently driven (binary index into tables)
//   last_o      out  current step is the final one
//   d_o..a_o    out  registered drive to the function block (D is MSB)
//
// Build option: KMAP4_GRAY_ORDER_EN (see kmap4_pkg).
// ----------------------------------------------------------------------------
module kmap4_vec_gen
  import kmap4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] minterm_o,
  output logic             last_o,
  output logic             d_o,
  output logic             c_o,
  output logic             b_o,
  output logic             a_o
);

  logic [IDX_W-1:0] step_q;
  logic [IDX_W-1:0] step_d;
  logic [IDX_W-1:0] minterm_q;

  always_comb begin
    step_d = step_q;
    if (load_i) begin
      step_d = '0;
    end else if (advance_i) begin
      step_d = step_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= '0;
      minterm_q <= '0;
    end else begin
      step_q    <= step_d;
      // The vector tracks the step on the same edge so the function block
      // sees the new inputs in the very first settle cycle.
      minterm_q <= step_to_minterm(step_d);
    end
  end

  assign minterm_o = minterm_q;
  assign last_o    = (step_q == IDX_W'(NUM_VECTORS - 1));
  assign d_o       = minterm_q[3];
  assign c_o       = minterm_q[2];
  assign b_o       = minterm_q[1];
  assign a_o       = minterm_q[0];

endmodule : kmap4_vec_gen

// File: rtl/kmap4_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// kmap4_sweep_ctrl
// Exhaustively sweeps a 4-input combinational block: drives each of the 16
// minterms, waits SETTLE_CYCLES, samples F into truth_table and counts
// disagreements against the expected mask.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   CNT_W          settle counter width, must hold SETTLE_CYCLES
//
// Ports:
//   clk, rst_n     clock (rising edge) / async active-low reset
//   start          begin a sweep, honoured only in IDLE
//   abort          drop the sweep in progress, no done pulse
//   expected[15:0] expected F per minterm, bit i <-> {D,C,B,A}==i
//   f_in           F from the function block
//   d/c/b/a_out    drive to the function block inputs (D is MSB)
//   busy           sweep in progress (low in DONE)
//   done           one-cycle pulse after a completed sweep
//   truth_table    sampled F, bit i = F at minterm i
//   mismatch_cnt   minterms where F differed from expected (0..16)
//   pass           completed sweep with zero mismatches
//
// Build option: KMAP4_GRAY_ORDER_EN selects Gray step order (see kmap4_pkg).
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; outputs hold last sweep's results
// SETTLE | current vector applied, settle counter running down
// SAMPLE | capture F for the current minterm, step or finish
// DONE   | publish done/pass, return to IDLE
// ----------------------------------------------------------------------------
module kmap4_sweep_ctrl
  import kmap4_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           expected,
  input  logic                  f_in,
  output logic                  d_out,
  output logic                  c_out,
  output logic                  b_out,
  output logic                  a_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           truth_table,
  output logic [MISMATCH_W-1:0] mismatch_cnt,
  output logic                  pass
);

  // Counter runs SETTLE_CYCLES-1 down to 0; reaching 0 is the last settle cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [15:0]             truth_table_q;
  logic [MISMATCH_W-1:0]   mismatch_cnt_q;

  logic                    vec_load;
  logic                    vec_advance;
  logic [IDX_W-1:0]        minterm;
  logic                    last_step;
  logic                    f_miss;

  assign vec_load    = (state_q == IDLE) && start;
  // abort wins over the SAMPLE-stage step so the vector freezes where it was.
  assign vec_advance = (state_q == SAMPLE) && !abort && !last_step;
  assign f_miss      = (f_in != expected[minterm]);

  kmap4_vec_gen u_vec_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (vec_load),
    .advance_i (vec_advance),
    .minterm_o (minterm),
    .last_o    (last_step),
    .d_o       (d_out),
    .c_o       (c_out),
    .b_o       (b_out),
    .a_o       (a_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      truth_table_q  <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          truth_table_q  <= '0;
          mismatch_cnt_q <= '0;
          pass_q         <= 1'b0;
          cnt_q          <= CNT_LOAD;
          busy_q         <= 1'b1;
          state_q        <= SETTLE;
        end
      end else if (abort) begin
        // Partial truth_table / mismatch_cnt are left for inspection.
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          SETTLE: begin
            if (cnt_q == '0) begin
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          SAMPLE: begin
            truth_table_q[minterm] <= f_in;
            if (f_miss) begin
              mismatch_cnt_q <= mismatch_cnt_q + MISMATCH_W'(1);
            end
            if (last_step) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= SETTLE;
            end
          end
          DONE: begin
            // mismatch_cnt already includes the final sample here.
            done_q  <= 1'b1;
            pass_q  <= (mismatch_cnt_q == '0);
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign truth_table  = truth_table_q;
  assign mismatch_cnt = mismatch_cnt_q;

endmodule : kmap4_sweep_ctrl

// File: tb/tb_kmap4_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_kmap4_sweep_ctrl
// Directed bench for kmap4_sweep_ctrl. Each accepted start pushes the
// expected sweep result into a queue; a monitor pops and compares whenever
// done pulses. A done with nothing queued is reported as unexpected.
// Build option KMAP4_GRAY_ORDER_EN changes only the expected vector order.
// ----------------------------------------------------------------------------
module tb_kmap4_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int LAT    = 16 * (SETTLE + 1) + 1;   // 49

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  mm;
    logic        pass;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expected = 16'h0000;
  logic        f_in;
  logic        d_out, c_out, b_out, a_out;
  logic        busy, done, pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;

  logic        use_kmap = 1'b1;
  logic        log_en = 1'b0;
  logic [3:0]  vlog[$];
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          start_cyc = 0;

  kmap4_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .f_in         (f_in),
    .d_out        (d_out),
    .c_out        (c_out),
    .b_out        (b_out),
    .a_out        (a_out),
    .busy         (busy),
    .done         (done),
    .truth_table  (truth_table),
    .mismatch_cnt (mismatch_cnt),
    .pass         (pass)
  );

  // Function block under test: F = D&C | ~B&A, or a stuck-at-1 output.
  assign f_in = use_kmap ? ((d_out & c_out) | (~b_out & a_out)) : 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] ord(input int s);
    logic [3:0] v;
    v = 4'(s);
`ifdef KMAP4_GRAY_ORDER_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  function automatic logic kmap_f(input logic [3:0] m);
    return (m[3] & m[2]) | (~m[1] & m[0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("truth_table", 32'(truth_table), 32'(e.tt));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mm));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("latency", 32'(cyc - start_cyc - 1), 32'(e.lat));
      end
    end
  end

  // Vector order logger
  always @(negedge clk) begin
    if (log_en && busy) begin
      if (vlog.size() == 0 || {d_out, c_out, b_out, a_out} != vlog[$])
        vlog.push_back({d_out, c_out, b_out, a_out});
    end
  end

  task automatic start_sweep(input exp_t e, input bit push);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done after %0d cycles, want done", name, budget);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_vec"}, 32'({d_out, c_out, b_out, a_out}), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_done"}, 32'(done), 32'h0);
    chk({name, "_tt"}, 32'(truth_table), 32'h0);
    chk({name, "_mm"}, 32'(mismatch_cnt), 32'h0);
    chk({name, "_pass"}, 32'(pass), 32'h0);
  endtask

  initial begin : stim
    exp_t e;
    logic [15:0] part_tt;
    int busy_low;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // 1: matching table, full latency, vector order
    use_kmap = 1'b1;
    expected = 16'hF222;
    log_en = 1'b1;
    e = '{tt: 16'hF222, mm: 5'd0, pass: 1'b1, lat: LAT};
    start_sweep(e, 1'b1);
    wait_done(80, "sweep1");
    log_en = 1'b0;
    chk("vlog_size", 32'(vlog.size()), 32'd16);
    for (int i = 0; i < 16 && i < vlog.size(); i++)
      chk($sformatf("vec_order[%0d]", i), 32'(vlog[i]), 32'(ord(i)));
    chk("busy_at_done", 32'(busy), 32'h0);
    @(negedge clk);
    chk("vec_hold", 32'({d_out, c_out, b_out, a_out}), 32'(ord(15)));
    chk("done_one_cycle", 32'(done), 32'h0);

    // 2: single mismatch at minterm 0
    expected = 16'hF223;
    e = '{tt: 16'hF222, mm: 5'd1, pass: 1'b0, lat: LAT};
    start_sweep(e, 1'b1);
    wait_done(80, "sweep2");

    // 3: stuck-at-1 against all-zero mask, counter reaches 16
    use_kmap = 1'b0;
    expected = 16'h0000;
    e = '{tt: 16'hFFFF, mm: 5'd16, pass: 1'b0, lat: LAT};
    start_sweep(e, 1'b1);
    wait_done(80, "sweep3");

    // 4: abort at cycle 20, then a clean sweep
    use_kmap = 1'b1;
    expected = 16'hF222;
    start_sweep(e, 1'b0);
    repeat (19) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_pass", 32'(pass), 32'h0);
    part_tt = 16'h0000;
    for (int s = 0; s < 6; s++) part_tt[ord(s)] = kmap_f(ord(s));
    chk("abort_partial_tt", 32'(truth_table), 32'(part_tt));
    chk("abort_partial_mm", 32'(mismatch_cnt), 32'h0);
    abort = 1'b1;                       // abort in IDLE must do nothing
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_tt", 32'(truth_table), 32'(part_tt));
    repeat (60) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 32'h0);
    e = '{tt: 16'hF222, mm: 5'd0, pass: 1'b1, lat: LAT};
    start_sweep(e, 1'b1);
    wait_done(80, "sweep_after_abort");

    // 5: asynchronous reset mid-sweep
    start_sweep(e, 1'b0);
    repeat (29) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'h0);

    // 6: start held through the whole sweep
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    sb.push_back(e);
    busy_low = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      if (!busy && !done) busy_low++;
    end
    start = 1'b0;
    chk("held_start_done_seen", 32'(done), 32'h1);
    chk("held_start_busy_low", 32'(busy_low), 32'd1);
    repeat (60) @(negedge clk);
    chk("held_start_no_restart", 32'(busy), 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kmap4_sweep_ctrl
